imem_boot_ctrl: RTL
===================

// Module: imem_boot_ctrl
// PURPOSE
// - Sequences the 256x8 instruction memory. At power-up it holds the CPU in reset and
//   accepts a program image byte-stream from the UART receiver, writing it into imem.
// - After the load it releases the CPU. It also muxes the imem address between the
//   loader and CPU fetch.
// - Sits between uart_rx, instr_mem (with write port) and the CPU core.
// PARAMETERS
// - SYNC_BYTE  8'hA5  frame start marker.
// - BOOT_WAIT  50000  idle cycles after reset with no SYNC before running existing imem.
// - RX_TIMEOUT 20000  max cycles between bytes inside a frame before abort.
// PORTS
// - clock        in   1  system clock
// - reset_n      in   1  asynchronous, active-low reset
// - rx_valid     in   1  one-cycle pulse: rx_data holds a received byte
// - rx_data      in   8  received byte
// - reload       in   1  pulse in RUN: re-enter load mode
// - cpu_addr     in   8  CPU fetch address (pc)
// - cpu_instr    out  8  fetch data to CPU (= mem_rdata)
// - cpu_reset_n  out  1  active-low reset to CPU core, registered
// - mem_addr     out  8  imem address: load_ptr in LOAD, else cpu_addr
// - mem_wdata    out  8  imem write data
// - mem_we       out  1  imem write strobe, one cycle per data byte
// - mem_rdata    in   8  imem read data (combinational)
// - loading      out  1  high in SYNC_WAIT/LEN/LOAD/CSUM
// - load_err     out  1  sticky checksum/timeout flag, cleared on next SYNC byte
// BEHAVIOUR
// - Reset values:
//   - state=BOOT
//   - cpu_reset_n=0, mem_we=0, mem_wdata=0, loading=1, load_err=0
//   - ptr=0, len=0, sum=0, timer=0
// - BOOT: wait for bytes.
//   - rx SYNC_BYTE -> LEN.
//   - Other bytes are ignored.
//   - timer reaching BOOT_WAIT-1 -> RUN.
// - LEN: the next byte is N. N=0 means 256. ptr<=0, sum<=0 -> LOAD.
// - LOAD: each rx_valid drives next cycle mem_we=1, mem_addr=ptr, mem_wdata=byte.
//   - sum<=sum+byte (mod 256), ptr<=ptr+1.
//   - After the Nth byte -> CSUM.
//   - ptr wraps 255->0 only on the terminal write.
// - CSUM: rx byte==sum -> RUN. Otherwise load_err=1 -> BOOT, and timer restarts.
// - Inter-byte timeout: in LEN/LOAD/CSUM, timer counts cycles since the last rx_valid.
//   - At RX_TIMEOUT-1: load_err=1 -> BOOT.
//   - Bytes already written stay in imem.
// - RUN: cpu_reset_n=1 one cycle after entry. loading=0. mem_addr=cpu_addr. rx ignored.
//   - reload -> BOOT, with cpu_reset_n=0 the same edge.
//   - In BOOT after a reload, the timer expiry returns to RUN.
// - rx_valid on the same cycle as timer expiry: the byte wins and the timer resets.
// - mem_we never asserts outside LOAD. cpu_reset_n stays low in every state but RUN.
// - Async reset mid-LOAD aborts immediately. Partial contents are not cleared.
// - cpu_instr = mem_rdata always; the CPU is in reset while the loader owns the bus.
// STRUCTURE
// - Shared package/header boot_defs:
//   - state encoding BOOT, LEN, LOAD, CSUM, RUN (3-bit localparams)
//   - SYNC_BYTE default
// - One sub-module, boot_timer: loadable down-counter with a clear input and an expire
//   output, sized $clog2(max(BOOT_WAIT,RX_TIMEOUT)).
// - Parent holds the FSM, ptr/len/sum registers and the address mux.
// TESTING (BOOT_WAIT=100, RX_TIMEOUT=40 in bench; behavioural 256x8 imem model)
// - No rx after reset:
//   - cpu_reset_n rises exactly BOOT_WAIT+1 cycles after reset_n deasserts.
//   - mem_we never pulses.
// - Frame A5,03,D0,E0,03,B3 (sum 0xB3):
//   - mem[0..2]=D0,E0,03, three mem_we pulses.
//   - Then RUN, cpu_reset_n=1, load_err=0.
// - Same frame with checksum 00:
//   - load_err=1, back in BOOT, cpu_reset_n=0.
//   - Then a timeout -> RUN.
// - Frame with N=00 and 256 bytes of value i:
//   - mem[i]=i for all i. Checksum 0x80 accepted. ptr wraps to 0.
// - A5,02,11 then silence for 40 cycles:
//   - load_err=1 and mem[0]=11.
//   - A next A5 clears load_err.
// - In RUN, pulse reload, send a valid 1-byte frame:
//   - cpu_reset_n low during the load.
//   - mem_addr follows cpu_addr again afterwards.
//   - Assert reset_n=0 mid-LOAD: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/imem_boot_ctrl_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encoding, default frame/timing constants and a timer sizing helper.
package imem_boot_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_BOOT = 3'd0,
      ST_LEN  = 3'd1,
      ST_LOAD = 3'd2,
      ST_CSUM = 3'd3,
      ST_RUN  = 3'd4
   } boot_state_t;

   localparam logic [7:0] DEF_SYNC_BYTE  = 8'hA5;
   localparam int         DEF_BOOT_WAIT  = 50000;
   localparam int         DEF_RX_TIMEOUT = 20000;

   // Counter width able to hold max(a,b)-1, never narrower than one bit.
   function automatic int timer_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m > 2) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/imem_boot_ctrl_boot_timer.sv
// Cycle timer shared by the boot-wait and inter-byte timeout paths.
// It counts clock cycles since the last clear and flags expiry once the
// count reaches the limit chosen by the parent for the current state.
module boot_timer #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic [WIDTH-1:0] limit,
   output logic             expire
);

   logic [WIDTH-1:0] count;

   // Restart on clear, otherwise advance until the limit is reached and hold there.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (!expire) begin
         count <= count + 1'b1;
      end
   end

   assign expire = (count == limit);

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot controller for the 256x8 instruction memory. Holds the CPU in reset
// while a framed program image (SYNC, N, N data bytes, checksum) arrives from
// the UART, writes it into imem, then releases the CPU and hands the imem
// address bus to the fetch path. Without a SYNC byte it boots the existing
// contents after BOOT_WAIT idle cycles.
module imem_boot_ctrl
   import imem_boot_ctrl_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE  = DEF_SYNC_BYTE,
   parameter int         BOOT_WAIT  = DEF_BOOT_WAIT,
   parameter int         RX_TIMEOUT = DEF_RX_TIMEOUT
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   input  logic       reload,
   input  logic [7:0] cpu_addr,
   output logic [7:0] cpu_instr,
   output logic       cpu_reset_n,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       mem_we,
   input  logic [7:0] mem_rdata,
   output logic       loading,
   output logic       load_err
);

   localparam int            TW         = timer_width(BOOT_WAIT, RX_TIMEOUT);
   localparam logic [TW-1:0] BOOT_LIMIT = TW'(BOOT_WAIT - 1);
   localparam logic [TW-1:0] RX_LIMIT   = TW'(RX_TIMEOUT - 1);

   boot_state_t   state;
   boot_state_t   state_nx;
   logic [7:0]    ptr;
   logic [7:0]    len;
   logic [7:0]    sum;
   logic [7:0]    wr_addr;
   logic [7:0]    wdata;
   logic          we;
   logic          term;
   logic          err;
   logic          cpu_run;
   logic          in_frame;
   logic          is_sync;
   logic          take_data;
   logic          last_byte;
   logic          set_err;
   logic          clr_err;
   logic          timer_clear;
   logic          timer_expire;
   logic [TW-1:0] timer_limit;

   assign in_frame  = (state == ST_LEN) || (state == ST_LOAD) || (state == ST_CSUM);
   assign is_sync   = rx_valid && (rx_data == SYNC_BYTE);
   // While the terminal write is still on the bus a new byte is the checksum, not data.
   assign take_data = (state == ST_LOAD) && rx_valid && !term;
   // len==0 encodes 256, so len-1 wraps to 255 and the compare still works.
   assign last_byte = (ptr == len - 8'd1);

   // Boot wait applies while idling in BOOT, the inter-byte limit inside a frame.
   // The timer restarts on any state change, on every in-frame byte and while running.
   assign timer_limit = (state == ST_BOOT) ? BOOT_LIMIT : RX_LIMIT;
   assign timer_clear = (state_nx != state) || (in_frame && rx_valid) || (state == ST_RUN);

   boot_timer #(
      .WIDTH (TW)
   ) u_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (timer_clear),
      .limit   (timer_limit),
      .expire  (timer_expire)
   );

   // Next-state logic; a received byte always takes priority over a timer expiry.
   always_comb begin
      state_nx = state;
      set_err  = 1'b0;
      clr_err  = 1'b0;
      case (state)
         ST_BOOT: begin
            if (is_sync) begin
               state_nx = ST_LEN;
               clr_err  = 1'b1;
            end else if (timer_expire) begin
               state_nx = ST_RUN;
            end
         end
         ST_LEN: begin
            if (rx_valid) begin
               state_nx = ST_LOAD;
            end else if (timer_expire) begin
               state_nx = ST_BOOT;
               set_err  = 1'b1;
            end
         end
         ST_LOAD: begin
            if (term) begin
               if (rx_valid) begin
                  if (rx_data == sum) begin
                     state_nx = ST_RUN;
                  end else begin
                     state_nx = ST_BOOT;
                     set_err  = 1'b1;
                  end
               end else begin
                  state_nx = ST_CSUM;
               end
            end else if (!rx_valid && timer_expire) begin
               state_nx = ST_BOOT;
               set_err  = 1'b1;
            end
         end
         ST_CSUM: begin
            if (rx_valid) begin
               if (rx_data == sum) begin
                  state_nx = ST_RUN;
               end else begin
                  state_nx = ST_BOOT;
                  set_err  = 1'b1;
               end
            end else if (timer_expire) begin
               state_nx = ST_BOOT;
               set_err  = 1'b1;
            end
         end
         ST_RUN: begin
            if (reload) begin
               state_nx = ST_BOOT;
            end
         end
         default: begin
            state_nx = ST_BOOT;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_BOOT;
      end else begin
         state <= state_nx;
      end
   end

   // Frame datapath: length capture, write strobe/data/address, running checksum and status flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr     <= 8'd0;
         len     <= 8'd0;
         sum     <= 8'd0;
         wr_addr <= 8'd0;
         wdata   <= 8'd0;
         we      <= 1'b0;
         term    <= 1'b0;
         err     <= 1'b0;
         cpu_run <= 1'b0;
      end else begin
         we      <= take_data;
         term    <= take_data && last_byte;
         cpu_run <= (state == ST_RUN) && (state_nx == ST_RUN);
         if (state == ST_LEN && rx_valid) begin
            len <= rx_data;
            ptr <= 8'd0;
            sum <= 8'd0;
         end
         if (take_data) begin
            wr_addr <= ptr;
            wdata   <= rx_data;
            sum     <= sum + rx_data;
            ptr     <= ptr + 8'd1;
         end
         if (set_err) begin
            err <= 1'b1;
         end else if (clr_err) begin
            err <= 1'b0;
         end
      end
   end

   assign cpu_instr   = mem_rdata;
   assign cpu_reset_n = cpu_run;
   assign mem_addr    = (state == ST_LOAD) ? wr_addr : cpu_addr;
   assign mem_wdata   = wdata;
   assign mem_we      = we;
   assign loading     = (state != ST_RUN);
   assign load_err    = err;

endmodule
